// File: rtl/spi_burst_pkg.sv
// Shared types and defaults for the SPI burst sequencer.
package spi_burst_pkg;

    localparam int MAX_LEN_DEF     = 16;
    localparam int TIMEOUT_CYC_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_FETCH,
        ST_TX_WAIT,
        ST_RX_REQ,
        ST_RX_WAIT,
        ST_RX_HOLD,
        ST_GAP,
        ST_FINISH
    } state_t;

    // Oversized byte counts are limited to the largest burst supported.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/spi_burst_wdog.sv
// Per-byte watchdog: loadable down-counter that flags expiry after
// TIMEOUT_CYC enabled cycles following a load.
module spi_burst_wdog
    import spi_burst_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Load on entry to a wait state, then count down to the terminal value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // The owner leaves the wait state on expiry, so this is a single-cycle strobe.
    assign o_expire = i_en && !i_load && !i_clr && (r_cnt == '0);

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of spi_module: pops N bytes from the TX stream
// into the SPI byte interface, then reads M bytes into the RX stream.
module spi_burst_ctrl
    import spi_burst_pkg::*;
#(
    parameter  int MAX_LEN     = MAX_LEN_DEF,
    parameter  int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_cmd_valid,
    output logic             O_cmd_ready,
    input  logic [LEN_W-1:0] I_cmd_wr_len,
    input  logic [LEN_W-1:0] I_cmd_rd_len,
    input  logic             I_tx_valid,
    output logic             O_tx_ready,
    input  logic [7:0]       I_tx_data,
    output logic             O_rx_valid,
    input  logic             I_rx_ready,
    output logic [7:0]       O_rx_data,
    output logic             O_busy,
    output logic             O_done,
    output logic             O_timeout,
    output logic             O_spi_tx_en,
    output logic             O_spi_rx_en,
    output logic [7:0]       O_spi_data_in,
    input  logic [7:0]       I_spi_data_out,
    input  logic             I_spi_tx_done,
    input  logic             I_spi_rx_done
);

    state_t           r_state;
    state_t           w_next_state;
    logic [LEN_W-1:0] r_wr_cnt;
    logic [LEN_W-1:0] r_rd_cnt;
    logic [7:0]       r_spi_data_in;
    logic [7:0]       r_rx_data;
    logic             r_done;
    logic             r_timeout;

    logic [LEN_W-1:0] w_wr_len_c;
    logic [LEN_W-1:0] w_rd_len_c;
    logic             w_cmd_acc;
    logic             w_tx_pop;
    logic             w_tx_hit;
    logic             w_rx_hit;
    logic             w_rx_hs;
    logic             w_wd_load;
    logic             w_wd_en;
    logic             w_wd_clr;
    logic             w_wd_expire;
    logic             w_abort;

    assign w_wr_len_c = LEN_W'(clamp_len(int'(I_cmd_wr_len), MAX_LEN));
    assign w_rd_len_c = LEN_W'(clamp_len(int'(I_cmd_rd_len), MAX_LEN));

    // Only the done pulse matching the current wait state is honoured.
    assign w_cmd_acc = I_cmd_valid && (r_state == ST_IDLE);
    assign w_tx_pop  = I_tx_valid && (r_state == ST_TX_FETCH);
    assign w_tx_hit  = I_spi_tx_done && (r_state == ST_TX_WAIT);
    assign w_rx_hit  = I_spi_rx_done && (r_state == ST_RX_WAIT);
    assign w_rx_hs   = I_rx_ready && (r_state == ST_RX_HOLD);

    // The watchdog only runs while an SPI byte is in flight; stream stalls do not count.
    assign w_wd_load = w_tx_pop || (r_state == ST_RX_REQ);
    assign w_wd_en   = (r_state == ST_TX_WAIT) || (r_state == ST_RX_WAIT);
    assign w_wd_clr  = (r_state == ST_IDLE);
    // A done arriving on the terminal cycle still wins over the abort.
    assign w_abort   = w_wd_expire && !w_tx_hit && !w_rx_hit;

    spi_burst_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .i_clk    (I_clk),
        .i_rst_n  (I_rst_n),
        .i_clr    (w_wd_clr),
        .i_load   (w_wd_load),
        .i_en     (w_wd_en),
        .o_expire (w_wd_expire)
    );

    // State register.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; GAP guarantees one idle cycle between SPI bytes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_acc) begin
                    if (w_wr_len_c != '0) begin
                        w_next_state = ST_TX_FETCH;
                    end else if (w_rd_len_c != '0) begin
                        w_next_state = ST_RX_REQ;
                    end else begin
                        w_next_state = ST_FINISH;
                    end
                end
            end
            ST_TX_FETCH: begin
                if (w_tx_pop) begin
                    w_next_state = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (w_tx_hit) begin
                    w_next_state = ST_GAP;
                end else if (w_abort) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RX_REQ: begin
                w_next_state = ST_RX_WAIT;
            end
            ST_RX_WAIT: begin
                if (w_rx_hit) begin
                    w_next_state = ST_RX_HOLD;
                end else if (w_abort) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RX_HOLD: begin
                if (w_rx_hs) begin
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_wr_cnt != '0) begin
                    w_next_state = ST_TX_FETCH;
                end else if (r_rd_cnt != '0) begin
                    w_next_state = ST_RX_REQ;
                end else begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; enables and valids fall as soon as the state leaves.
    always_comb begin
        O_cmd_ready = 1'b0;
        O_busy      = 1'b1;
        O_tx_ready  = 1'b0;
        O_rx_valid  = 1'b0;
        O_spi_tx_en = 1'b0;
        O_spi_rx_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                O_cmd_ready = 1'b1;
                O_busy      = 1'b0;
            end
            ST_TX_FETCH: O_tx_ready  = I_tx_valid;
            ST_TX_WAIT:  O_spi_tx_en = 1'b1;
            ST_RX_WAIT:  O_spi_rx_en = 1'b1;
            ST_RX_HOLD:  O_rx_valid  = 1'b1;
            default: begin
            end
        endcase
    end

    // Remaining byte counts: latched on accept, never decremented below zero.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if (w_cmd_acc) begin
            r_wr_cnt <= w_wr_len_c;
            r_rd_cnt <= w_rd_len_c;
        end else if (w_abort) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_tx_hit && (r_wr_cnt != '0)) begin
                r_wr_cnt <= r_wr_cnt - LEN_W'(1);
            end
            if (w_rx_hs && (r_rd_cnt != '0)) begin
                r_rd_cnt <= r_rd_cnt - LEN_W'(1);
            end
        end
    end

    // Byte holding registers for the SPI input and the RX stream output.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_spi_data_in <= '0;
            r_rx_data     <= '0;
        end else begin
            if (w_tx_pop) begin
                r_spi_data_in <= I_tx_data;
            end
            if (w_rx_hit) begin
                r_rx_data <= I_spi_data_out;
            end
        end
    end

    // Completion and abort strobes, registered so they are glitch-free.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= (r_state == ST_FINISH);
            r_timeout <= w_abort;
        end
    end

    assign O_spi_data_in = r_spi_data_in;
    assign O_rx_data     = r_rx_data;
    assign O_done        = r_done;
    assign O_timeout     = r_timeout;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a behavioural spi_module responder
// and scoreboard queues for SPI-side TX bytes and RX stream bytes.
module tb_spi_burst_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TO_CYC  = 64;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             I_clk = 1'b0;
    logic             I_rst_n;
    logic             I_cmd_valid;
    logic             O_cmd_ready;
    logic [LEN_W-1:0] I_cmd_wr_len;
    logic [LEN_W-1:0] I_cmd_rd_len;
    logic             I_tx_valid;
    logic             O_tx_ready;
    logic [7:0]       I_tx_data;
    logic             O_rx_valid;
    logic             I_rx_ready;
    logic [7:0]       O_rx_data;
    logic             O_busy;
    logic             O_done;
    logic             O_timeout;
    logic             O_spi_tx_en;
    logic             O_spi_rx_en;
    logic [7:0]       O_spi_data_in;
    logic [7:0]       I_spi_data_out;
    logic             I_spi_tx_done;
    logic             I_spi_rx_done;

    spi_burst_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .I_clk          (I_clk),
        .I_rst_n        (I_rst_n),
        .I_cmd_valid    (I_cmd_valid),
        .O_cmd_ready    (O_cmd_ready),
        .I_cmd_wr_len   (I_cmd_wr_len),
        .I_cmd_rd_len   (I_cmd_rd_len),
        .I_tx_valid     (I_tx_valid),
        .O_tx_ready     (O_tx_ready),
        .I_tx_data      (I_tx_data),
        .O_rx_valid     (O_rx_valid),
        .I_rx_ready     (I_rx_ready),
        .O_rx_data      (O_rx_data),
        .O_busy         (O_busy),
        .O_done         (O_done),
        .O_timeout      (O_timeout),
        .O_spi_tx_en    (O_spi_tx_en),
        .O_spi_rx_en    (O_spi_rx_en),
        .O_spi_data_in  (O_spi_data_in),
        .I_spi_data_out (I_spi_data_out),
        .I_spi_tx_done  (I_spi_tx_done),
        .I_spi_rx_done  (I_spi_rx_done)
    );

    always #5 I_clk = ~I_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] tx_stream_q[$];
    logic [7:0] exp_spi_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] rx_model_q[$];

    logic stream_en = 1'b1;
    logic tx_hang   = 1'b0;
    logic rx_hang   = 1'b0;
    logic spur_req  = 1'b0;
    logic spur_sent = 1'b0;
    logic tx_hs     = 1'b0;

    int n_pop, n_done, n_timeout, n_txen_rise, n_rx_hs, n_both;
    int done_cyc, to_cyc, txen_rise_cyc, rxen_rise_cyc, rx_hs_cyc;
    logic prev_tx_en = 1'b0;
    logic prev_rx_en = 1'b0;
    logic [7:0] held_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_pop = 0; n_done = 0; n_timeout = 0; n_txen_rise = 0; n_rx_hs = 0;
        done_cyc = -1; to_cyc = -1; txen_rise_cyc = -1; rxen_rise_cyc = -1; rx_hs_cyc = -1;
    endtask

    always @(posedge I_clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, pops scoreboards on DUT events.
    always @(negedge I_clk) begin
        logic [7:0] e;
        tx_hs = O_tx_ready && I_tx_valid;
        if (tx_hs) n_pop++;
        if (O_spi_tx_en && !prev_tx_en) begin
            n_txen_rise++;
            txen_rise_cyc = cyc;
            held_data = O_spi_data_in;
            e = 8'hxx;
            if (exp_spi_q.size() > 0) e = exp_spi_q.pop_front();
            chk("spi_data", {24'h0, O_spi_data_in}, {24'h0, e});
        end else if (O_spi_tx_en) begin
            chk("spi_data_stable", {24'h0, O_spi_data_in}, {24'h0, held_data});
        end
        if (O_spi_rx_en && !prev_rx_en) rxen_rise_cyc = cyc;
        if (O_spi_tx_en && O_spi_rx_en) n_both++;
        if (O_rx_valid && I_rx_ready) begin
            n_rx_hs++;
            rx_hs_cyc = cyc;
            e = 8'hxx;
            if (exp_rx_q.size() > 0) e = exp_rx_q.pop_front();
            chk("rx_data", {24'h0, O_rx_data}, {24'h0, e});
        end
        if (O_done) begin n_done++; done_cyc = cyc; end
        if (O_timeout) begin n_timeout++; to_cyc = cyc; end
        prev_tx_en = O_spi_tx_en;
        prev_rx_en = O_spi_rx_en;
    end

    // TX byte stream source.
    always begin
        @(posedge I_clk);
        #1;
        if (tx_hs && tx_stream_q.size() > 0) void'(tx_stream_q.pop_front());
        tx_hs = 1'b0;
        I_tx_valid = stream_en && (tx_stream_q.size() > 0);
        I_tx_data  = (tx_stream_q.size() > 0) ? tx_stream_q[0] : 8'h00;
    end

    // spi_module model: tx_done 10 cycles after tx_en, rx_done 5 cycles after rx_en.
    int  m_tx_cnt = 0, m_rx_cnt = 0;
    logic m_tx_act = 1'b0, m_rx_act = 1'b0;
    always begin
        @(posedge I_clk);
        #1;
        I_spi_tx_done = 1'b0;
        I_spi_rx_done = 1'b0;
        if (O_spi_tx_en) begin
            if (!m_tx_act) begin m_tx_act = 1'b1; m_tx_cnt = 1; end
            else m_tx_cnt++;
            if (m_tx_cnt == 10 && !tx_hang) I_spi_tx_done = 1'b1;
            if (spur_req && m_tx_cnt == 3) begin
                I_spi_rx_done = 1'b1;
                I_spi_data_out = 8'hEE;
                spur_req = 1'b0;
                spur_sent = 1'b1;
            end
        end else begin
            m_tx_act = 1'b0;
        end
        if (O_spi_rx_en) begin
            if (!m_rx_act) begin m_rx_act = 1'b1; m_rx_cnt = 1; end
            else m_rx_cnt++;
            if (m_rx_cnt == 5 && !rx_hang) begin
                I_spi_rx_done = 1'b1;
                I_spi_data_out = (rx_model_q.size() > 0) ? rx_model_q.pop_front() : 8'h00;
            end
        end else begin
            m_rx_act = 1'b0;
        end
    end

    task automatic send_cmd(input int wr, input int rd, output int acc);
        int n = 0;
        @(posedge I_clk);
        #1;
        I_cmd_valid  = 1'b1;
        I_cmd_wr_len = LEN_W'(wr);
        I_cmd_rd_len = LEN_W'(rd);
        acc = -1;
        while (acc < 0 && n < 50) begin
            @(negedge I_clk);
            if (O_cmd_ready) acc = cyc;
            else n++;
        end
        @(posedge I_clk);
        #1;
        I_cmd_valid = 1'b0;
        chk("cmd_accepted", {31'h0, acc >= 0}, 32'h1);
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (n_done == 0 && n_timeout == 0 && n < budget) begin
            @(posedge I_clk);
            n++;
        end
        chk({tag, "_ended"}, {31'h0, (n_done + n_timeout) > 0}, 32'h1);
        repeat (3) @(posedge I_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int acc;
        int n;
        I_rst_n = 1'b0; I_cmd_valid = 1'b0; I_cmd_wr_len = '0; I_cmd_rd_len = '0;
        I_rx_ready = 1'b1; I_spi_data_out = 8'h00; I_spi_tx_done = 1'b0; I_spi_rx_done = 1'b0;
        I_tx_valid = 1'b0; I_tx_data = 8'h00;
        n_both = 0;
        clr_stats();
        repeat (3) @(posedge I_clk);
        #1;
        chk("rst_ctrl", {24'h0, O_cmd_ready, O_busy, O_done, O_timeout, O_spi_tx_en,
                         O_spi_rx_en, O_tx_ready, O_rx_valid}, 32'h80);
        chk("rst_data", {16'h0, O_spi_data_in, O_rx_data}, 32'h0);
        I_rst_n = 1'b1;

        // Write three bytes.
        clr_stats();
        tx_stream_q.push_back(8'hA5); exp_spi_q.push_back(8'hA5);
        tx_stream_q.push_back(8'h3C); exp_spi_q.push_back(8'h3C);
        tx_stream_q.push_back(8'hFF); exp_spi_q.push_back(8'hFF);
        send_cmd(3, 0, acc);
        wait_end("wr3", 200);
        chk("wr3_pops", n_pop, 3);
        chk("wr3_txen_rises", n_txen_rise, 3);
        chk("wr3_done", n_done, 1);
        chk("wr3_timeout", n_timeout, 0);
        chk("wr3_sb_left", exp_spi_q.size(), 0);
        chk("wr3_idle", {31'h0, O_cmd_ready}, 32'h1);

        // Read two bytes with a stalled consumer on the first.
        clr_stats();
        I_rx_ready = 1'b0;
        rx_model_q.push_back(8'h81); exp_rx_q.push_back(8'h81);
        rx_model_q.push_back(8'h7E); exp_rx_q.push_back(8'h7E);
        send_cmd(0, 2, acc);
        n = 0;
        while (!O_rx_valid && n < 100) begin @(negedge I_clk); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("rd2_hold", {23'h0, O_rx_valid, O_rx_data}, {23'h0, 1'b1, 8'h81});
            @(posedge I_clk);
            #1;
            if (i == 4) I_rx_ready = 1'b1;
            @(negedge I_clk);
        end
        wait_end("rd2", 200);
        chk("rd2_hs", n_rx_hs, 2);
        chk("rd2_done", n_done, 1);
        chk("rd2_sb_left", exp_rx_q.size(), 0);
        chk("rd2_done_after_hs", {31'h0, done_cyc > rx_hs_cyc}, 32'h1);

        // Mixed burst with a stray rx_done while the TX byte is in flight.
        clr_stats();
        spur_sent = 1'b0;
        spur_req = 1'b1;
        tx_stream_q.push_back(8'h5A); exp_spi_q.push_back(8'h5A);
        rx_model_q.push_back(8'h42); exp_rx_q.push_back(8'h42);
        send_cmd(1, 1, acc);
        wait_end("mix", 200);
        chk("mix_spur_sent", {31'h0, spur_sent}, 32'h1);
        chk("mix_pops", n_pop, 1);
        chk("mix_rx_hs", n_rx_hs, 1);
        chk("mix_done", n_done, 1);
        chk("mix_order", {31'h0, (txen_rise_cyc >= 0) && (txen_rise_cyc < rxen_rise_cyc)}, 32'h1);
        chk("mix_sb_left", exp_spi_q.size() + exp_rx_q.size(), 0);

        // Watchdog abort on a TX byte that never completes.
        clr_stats();
        tx_hang = 1'b1;
        tx_stream_q.push_back(8'hB1); exp_spi_q.push_back(8'hB1);
        tx_stream_q.push_back(8'hB2);
        send_cmd(2, 0, acc);
        wait_end("to", 300);
        repeat (10) @(posedge I_clk);
        #1;
        chk("to_pulses", n_timeout, 1);
        chk("to_latency", to_cyc - txen_rise_cyc, TO_CYC);
        chk("to_no_done", n_done, 0);
        chk("to_pops", n_pop, 1);
        chk("to_b2_kept", tx_stream_q.size(), 1);
        chk("to_idle", {30'h0, O_cmd_ready, O_spi_tx_en}, 32'h2);
        tx_hang = 1'b0;
        tx_stream_q.delete();
        repeat (2) @(posedge I_clk);
        #1;

        // Reset in the middle of a read burst.
        clr_stats();
        rx_hang = 1'b1;
        send_cmd(0, 4, acc);
        n = 0;
        while (!O_spi_rx_en && n < 50) begin @(posedge I_clk); #1; n++; end
        chk("rstmid_in_rxwait", {31'h0, O_spi_rx_en}, 32'h1);
        #2;
        I_rst_n = 1'b0;
        #1;
        chk("rstmid_ctrl", {24'h0, O_cmd_ready, O_busy, O_done, O_timeout, O_spi_tx_en,
                            O_spi_rx_en, O_tx_ready, O_rx_valid}, 32'h80);
        chk("rstmid_data", {16'h0, O_spi_data_in, O_rx_data}, 32'h0);
        repeat (2) @(posedge I_clk);
        #1;
        I_rst_n = 1'b1;
        rx_hang = 1'b0;
        chk("rstmid_no_pulse", n_done + n_timeout, 0);
        clr_stats();
        send_cmd(0, 0, acc);
        wait_end("zero", 20);
        chk("zero_latency", done_cyc - acc, 2);
        chk("zero_done", n_done, 1);

        // Clamped length with a long TX stream stall.
        clr_stats();
        stream_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tx_stream_q.push_back(8'(8'h10 + i));
            if (i < MAX_LEN) exp_spi_q.push_back(8'(8'h10 + i));
        end
        send_cmd(20, 0, acc);
        repeat (1000) @(posedge I_clk);
        #1;
        chk("stall_no_timeout", n_timeout, 0);
        chk("stall_no_pop", n_pop, 0);
        chk("stall_busy", {31'h0, O_busy}, 32'h1);
        stream_en = 1'b1;
        wait_end("clamp", 1000);
        chk("clamp_pops", n_pop, MAX_LEN);
        chk("clamp_txen_rises", n_txen_rise, MAX_LEN);
        chk("clamp_done", n_done, 1);
        chk("clamp_timeout", n_timeout, 0);
        chk("clamp_left", tx_stream_q.size(), 4);
        chk("clamp_sb_left", exp_spi_q.size(), 0);
        tx_stream_q.delete();

        chk("no_en_overlap", n_both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_burst_ctrl.md
Name: spi_burst_ctrl

Overview:
- Transaction sequencer that sits directly upstream of spi_module and drives its byte-level enable/data/done interface.
- Accepts one burst command: write N bytes pulled from a TX byte stream, then read M bytes pushed to an RX byte stream.
- Generates spi_module's I_tx_en/I_rx_en/I_data_in and consumes its O_tx_done/O_rx_done/O_data_out.
- Reports completion and a per-byte watchdog timeout.

Parameters:
- MAX_LEN, 16, maximum write or read byte count per command.
- LEN_W, $clog2(MAX_LEN+1), width of the length fields (derived, not overridden).
- TIMEOUT_CYC, 4096, clocks allowed per byte between enable assertion and the matching done pulse.

Ports:
- I_clk  in  1  system clock; single clock domain.
- I_rst_n  in  1  asynchronous active-low reset.
- I_cmd_valid  in  1  command offered.
- O_cmd_ready  out  1  high only in IDLE; command is accepted when valid && ready.
- I_cmd_wr_len  in  LEN_W  write byte count, 0..MAX_LEN.
- I_cmd_rd_len  in  LEN_W  read byte count, 0..MAX_LEN.
- I_tx_valid  in  1  TX stream byte available.
- O_tx_ready  out  1  TX stream pop strobe.
- I_tx_data  in  8  TX stream byte.
- O_rx_valid  out  1  RX byte available; held until accepted.
- I_rx_ready  in  1  RX consumer ready.
- O_rx_data  out  8  received byte.
- O_busy  out  1  high whenever the FSM is not in IDLE.
- O_done  out  1  one-cycle pulse when a burst completes.
- O_timeout  out  1  one-cycle pulse when a burst is aborted by the watchdog.
- O_spi_tx_en  out  1  to spi_module I_tx_en.
- O_spi_rx_en  out  1  to spi_module I_rx_en.
- O_spi_data_in  out  8  to spi_module I_data_in.
- I_spi_data_out  in  8  from spi_module O_data_out.
- I_spi_tx_done  in  1  from spi_module O_tx_done; one-cycle pulse.
- I_spi_rx_done  in  1  from spi_module O_rx_done; one-cycle pulse.

Behaviour:
- Reset (I_rst_n low, asynchronous):
  - All outputs are 0, except O_cmd_ready = 1.
  - FSM returns to IDLE; counters and watchdog clear.
  - Any in-flight command is dropped.
  - No output toggles during reset.
- States: IDLE, TX_FETCH, TX_WAIT, RX_REQ, RX_WAIT, RX_HOLD, GAP, FINISH.
- IDLE:
  - On cmd handshake, latch wr_len and rd_len.
  - wr_len > 0 goes to TX_FETCH; else rd_len > 0 goes to RX_REQ; else FINISH.
- TX_FETCH:
  - O_tx_ready = I_tx_valid (combinational pop).
  - On pop, register I_tx_data into O_spi_data_in, assert O_spi_tx_en next cycle, and go to TX_WAIT.
  - While the stream is empty, wait indefinitely; the watchdog does not run.
- TX_WAIT:
  - O_spi_tx_en and O_spi_data_in hold stable; the watchdog counts.
  - On I_spi_tx_done: drop tx_en, decrement the write count, and go to GAP.
- GAP:
  - Exactly one cycle with both enables low.
  - Next state: TX_FETCH if write bytes remain; else RX_REQ if read bytes remain; else FINISH.
- RX_REQ: assert O_spi_rx_en, then go to RX_WAIT.
- RX_WAIT:
  - O_spi_rx_en holds; the watchdog counts.
  - On I_spi_rx_done: capture I_spi_data_out into O_rx_data, drop rx_en, and go to RX_HOLD.
- RX_HOLD:
  - O_rx_valid = 1 until I_rx_ready; the watchdog does not run.
  - After the handshake, decrement the read count and go to GAP.
- FINISH: O_done pulses for 1 cycle, then IDLE.
- Watchdog:
  - Counter clears on entry to TX_WAIT/RX_WAIT.
  - When it reaches TIMEOUT_CYC-1 without the matching done: drop enables, pulse O_timeout (O_done stays 0), discard remaining bytes (no further TX pops), and return to IDLE.
- Done pulses:
  - A done pulse not matching the current wait state is ignored: rx_done in TX_WAIT, tx_done in RX_WAIT, or either in any other state.
  - A simultaneous tx_done and rx_done in TX_WAIT honours tx_done only.
- Length rules:
  - Lengths greater than MAX_LEN are clamped to MAX_LEN at latch.
  - Counters never wrap below 0.
- Throughput: a single command has minimum latency of 2 cycles (IDLE → FINISH → IDLE) with wr_len = rd_len = 0.
- I_cmd_valid while busy is ignored; O_cmd_ready is low in that case.

Decomposition:
- Package spi_burst_pkg:
  - typedef enum for the FSM state.
  - localparam default MAX_LEN and TIMEOUT_CYC.
  - function clamp_len.
- One sub-module: spi_burst_wdog, a loadable down-counter with clear/enable and a one-cycle expire output.
- Everything else stays in the top module.

Test Plan:
- Write 3 bytes: cmd wr=3, rd=0; TX stream offers A5, 3C, FF; spi model pulses tx_done 10 cycles after each tx_en.
  → O_spi_data_in sequence is A5, 3C, FF; tx_en is low ≥1 cycle between bytes; O_done pulses once; O_tx_ready fires exactly 3 times.
- Read 2 bytes: cmd wr=0, rd=2; model returns 81, 7E; I_rx_ready is held low 5 cycles on the first byte.
  → O_rx_data 81 stays valid for those 5 cycles, then 7E; O_done pulses after the second handshake.
- Mixed burst: cmd wr=1, rd=1 with a spurious rx_done during TX_WAIT.
  → the spurious pulse is ignored; order is tx then rx; exactly one RX byte is delivered.
- Timeout: TIMEOUT_CYC=64, cmd wr=2; the model never pulses tx_done.
  → O_timeout pulses 64 cycles after tx_en rises; O_done stays 0; the second TX byte is not popped; O_cmd_ready = 1 afterwards.
- Reset mid-burst: assert I_rst_n low during RX_WAIT of cmd rd=4.
  → all enables and valids go to 0 immediately; after release, a new wr=0, rd=0 command yields O_done exactly 2 cycles after acceptance.
- Clamp and empty stream: cmd wr=20 (MAX_LEN=16); TX stream is empty for 1000 cycles, then supplies bytes.
  → no timeout fires during the stall; exactly 16 bytes are sent.
